// File: rtl/relu_act.sv
// In-place ReLU over Height_i bus words of RAM_WIDTH bits (signed 32-bit lanes).
// Optional macro RELU_LEAKY_EN: negative lanes become lane >>> LeakyBp_i instead of 0.
`timescale 1ns/1ps
module relu_act #(
    parameter logic [63:0] ShareMemAddr    = 64'h0,
    parameter logic [63:0] PrivateMemAddr0 = 64'h0,
    parameter logic [63:0] PrivateMemAddr1 = 64'h0,
    parameter logic [63:0] PrivateMemAddr2 = 64'h0,
    parameter logic [63:0] PrivateMemAddr3 = 64'h0,
    parameter int unsigned RAM_WIDTH       = 512
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [2:0]           select,
    input  logic [8:0]           Height_i,
    input  logic [3:0]           LeakyBp_i,
    input  logic                 Req_i,
    output logic                 Ack_o,
    output logic [63:0]          Addr_o,
    output logic                 Read_o,
    output logic                 Write_o,
    output logic [63:0]          ByteEnable_o,
    output logic [RAM_WIDTH-1:0] WriteData_o,
    input  logic [RAM_WIDTH-1:0] ReadData_i,
    output logic                 Lock_o,
    input  logic                 WaitReq_i
);

    localparam int unsigned Lanes = RAM_WIDTH / 32;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, PROC, WR_REQ, ADV, DONE
    } state_e;

    state_e               state_q, state_d;
    logic [63:0]          addr_q, addr_d;
    logic [8:0]           cnt_q, cnt_d;
    logic                 wait_q, wait_d;
    logic [RAM_WIDTH-1:0] rdata_q, rdata_d;
    logic [RAM_WIDTH-1:0] result_q, result_d;
    logic [RAM_WIDTH-1:0] relu_w;
    logic [63:0]          base;
    logic signed [31:0]   lane;

`ifndef RELU_LEAKY_EN
    logic unused_bp;
    assign unused_bp = ^LeakyBp_i;
`endif

    always_comb begin
        case (select)
            3'b000:  base = ShareMemAddr;
            3'b001:  base = PrivateMemAddr0;
            3'b010:  base = PrivateMemAddr1;
            3'b011:  base = PrivateMemAddr2;
            3'b100:  base = PrivateMemAddr3;
            default: base = '0;
        endcase
    end

    always_comb begin
        relu_w = '0;
        lane   = '0;
        for (int unsigned k = 0; k < Lanes; k++) begin
            lane = rdata_q[k*32 +: 32];
`ifdef RELU_LEAKY_EN
            relu_w[k*32 +: 32] = lane[31] ? (lane >>> LeakyBp_i) : lane;
`else
            relu_w[k*32 +: 32] = lane[31] ? 32'h0 : lane;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        rdata_d  = rdata_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (Req_i) begin
                    if (Height_i == 9'd0 || select > 3'b100) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD_REQ;
                        addr_d  = base;
                        cnt_d   = Height_i;
                    end
                end
            end
            RD_REQ: begin
                if (!WaitReq_i) begin
                    state_d = RD_WAIT;
                    wait_d  = 1'b0;
                end
            end
            // Two-cycle read latency: data is sampled in the second wait cycle.
            RD_WAIT: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else begin
                    rdata_d = ReadData_i;
                    state_d = PROC;
                end
            end
            PROC: begin
                result_d = relu_w;
                state_d  = WR_REQ;
            end
            WR_REQ: begin
                if (!WaitReq_i) state_d = ADV;
            end
            ADV: begin
                addr_d  = addr_q + 64'd1;
                cnt_d   = cnt_q - 9'd1;
                state_d = (cnt_q == 9'd1) ? DONE : RD_REQ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            wait_q   <= 1'b0;
            rdata_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            rdata_q  <= rdata_d;
            result_q <= result_d;
        end
    end

    assign Read_o       = (state_q == RD_REQ) && !WaitReq_i;
    assign Write_o      = (state_q == WR_REQ) && !WaitReq_i;
    assign Ack_o        = (state_q == DONE);
    assign Lock_o       = (state_q != IDLE) && (state_q != DONE);
    assign Addr_o       = addr_q;
    assign WriteData_o  = result_q;
    assign ByteEnable_o = '1;

endmodule

// File: tb/tb_relu_act.sv
// Randomized self-checking bench for relu_act with a bus memory model and a
// lane-arithmetic reference; build with +define+RELU_LEAKY_EN for the leaky variant.
`timescale 1ns/1ps
module tb_relu_act;

    localparam int unsigned W = 128;
    localparam int unsigned L = W / 32;
    localparam logic [63:0] B0 = 64'h100;
    localparam logic [63:0] B1 = 64'h200;
    localparam logic [63:0] B2 = 64'h300;
    localparam logic [63:0] B3 = 64'h1000;
    localparam logic [63:0] B4 = 64'hFFFF_FFFF_FFFF_FFFE;
`ifdef RELU_LEAKY_EN
    localparam bit Leaky = 1'b1;
`else
    localparam bit Leaky = 1'b0;
`endif

    logic         clk, rstn, Req_i, Ack_o, Read_o, Write_o, Lock_o, WaitReq_i;
    logic [2:0]   select;
    logic [8:0]   Height_i;
    logic [3:0]   LeakyBp_i;
    logic [63:0]  Addr_o, ByteEnable_o;
    logic [W-1:0] WriteData_o, ReadData_i;

    relu_act #(
        .ShareMemAddr(B0), .PrivateMemAddr0(B1), .PrivateMemAddr1(B2),
        .PrivateMemAddr2(B3), .PrivateMemAddr3(B4), .RAM_WIDTH(W)
    ) dut (
        .clk(clk), .rstn(rstn), .select(select), .Height_i(Height_i),
        .LeakyBp_i(LeakyBp_i), .Req_i(Req_i), .Ack_o(Ack_o), .Addr_o(Addr_o),
        .Read_o(Read_o), .Write_o(Write_o), .ByteEnable_o(ByteEnable_o),
        .WriteData_o(WriteData_o), .ReadData_i(ReadData_i), .Lock_o(Lock_o),
        .WaitReq_i(WaitReq_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [W-1:0] mem [logic [63:0]];
    logic [63:0]  exp_rd[$];
    logic [63:0]  exp_wa[$];
    logic [W-1:0] exp_wd[$];
    int           ack_cnt = 0;
    int           rd_cnt  = 0;
    int           wr_cnt  = 0;
    logic [63:0]  last_rd_addr = '0;

    function automatic logic [31:0] ref_lane(input logic [31:0] raw, input int bp);
        longint v, p, q;
        v = longint'($signed(raw));
        if (v >= 0) return raw;
        p = longint'(1) << bp;
        q = v / p;
        if (q * p != v) q = q - 1;
        return Leaky ? q[31:0] : 32'h0;
    endfunction

    function automatic logic [W-1:0] ref_word(input logic [W-1:0] w, input int bp);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < L; i++) r[i*32 +: 32] = ref_lane(w[i*32 +: 32], bp);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_word(input bit special);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < L; i++) begin
            case (special ? $urandom_range(0, 4) : 0)
                1: r[i*32 +: 32] = 32'h0;
                2: r[i*32 +: 32] = 32'h8000_0000;
                3: r[i*32 +: 32] = 32'(-int'($urandom_range(1, 100)));
                4: r[i*32 +: 32] = 32'($urandom_range(1, 100));
                default: r[i*32 +: 32] = $urandom;
            endcase
        end
        return r;
    endfunction

    // Bus observer: sampled mid-cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (Ack_o) ack_cnt++;
        if (Read_o) begin
            rd_cnt++;
            last_rd_addr = Addr_o;
            check("rd_wr_excl", W'(Write_o), '0);
            check("lock_rd", W'(Lock_o), W'(1));
            if (exp_rd.size() == 0) check("rd_extra", W'(Read_o), '0);
            else check("rd_addr", W'(Addr_o), W'(exp_rd.pop_front()));
        end
        if (Write_o) begin
            wr_cnt++;
            check("lock_wr", W'(Lock_o), W'(1));
            check("be_ones", W'(ByteEnable_o), W'(64'hFFFF_FFFF_FFFF_FFFF));
            if (exp_wa.size() == 0) check("wr_extra", W'(Write_o), '0);
            else begin
                check("wr_addr", W'(Addr_o), W'(exp_wa.pop_front()));
                check("wr_data", WriteData_o, exp_wd.pop_front());
            end
            mem[Addr_o] = WriteData_o;
        end
    end

    // Memory read pipe: data is valid only in the cycle two after the read strobe.
    initial begin
        int seen;
        logic d1v, d2v;
        logic [63:0] d1a, d2a;
        seen = 0; d1v = 1'b0; d2v = 1'b0; d1a = '0; d2a = '0;
        ReadData_i = '0;
        forever begin
            @(posedge clk); #1;
            d2v = d1v; d2a = d1a;
            d1v = (rd_cnt != seen); d1a = last_rd_addr;
            seen = rd_cnt;
            if (d2v && mem.exists(d2a)) ReadData_i = mem[d2a];
            else ReadData_i = rand_word(1'b0);
        end
    end

    function automatic logic [63:0] base_of(input logic [2:0] sel);
        case (sel)
            3'd0: return B0;
            3'd1: return B1;
            3'd2: return B2;
            3'd3: return B3;
            3'd4: return B4;
            default: return '0;
        endcase
    endfunction

    task automatic start_job(input logic [2:0] sel, input logic [8:0] h, input logic [3:0] bp,
                             input bit fill, input bit stall_rd);
        logic [63:0] a;
        if (h != 0 && sel <= 3'd4) begin
            for (int i = 0; i < int'(h); i++) begin
                a = base_of(sel) + 64'(i);
                if (fill) mem[a] = rand_word(1'b1);
                exp_rd.push_back(a);
                exp_wa.push_back(a);
                exp_wd.push_back(ref_word(mem[a], int'(bp)));
            end
        end
        @(posedge clk); #1;
        Req_i = 1'b1; select = sel; Height_i = h; LeakyBp_i = bp; WaitReq_i = stall_rd;
        @(posedge clk); #1;
        Req_i = 1'b0; select = 3'($urandom); Height_i = 9'($urandom);
    endtask

    task automatic run_job(input logic [2:0] sel, input logic [8:0] h, input logic [3:0] bp,
                           input bit rnd, input bit stall_rd, input bit stall_wr, input bit fill);
        int a0, r0, w0, cyc;
        bit valid;
        valid = (h != 0) && (sel <= 3'd4);
        a0 = ack_cnt; r0 = rd_cnt; w0 = wr_cnt;
        start_job(sel, h, bp, fill, stall_rd && valid);
        if (stall_rd && valid) begin
            repeat (4) begin
                @(negedge clk);
                check("stall_rd", W'(Read_o), '0);
                check("stall_lock", W'(Lock_o), W'(1));
                @(posedge clk); #1;
            end
            WaitReq_i = 1'b0;
        end
        if (stall_wr && valid) begin
            cyc = 0;
            while (rd_cnt == r0 && cyc < 50) begin @(negedge clk); cyc++; end
            check("rd_seen", W'(rd_cnt != r0), W'(1));
            repeat (4) @(posedge clk);
            #1 WaitReq_i = 1'b1;
            repeat (4) begin
                @(negedge clk);
                check("stall_wr", W'(Write_o), '0);
                check("stall_wd", WriteData_o, exp_wd[0]);
                @(posedge clk); #1;
            end
            WaitReq_i = 1'b0;
        end
        cyc = 0;
        while (ack_cnt == a0 && cyc < 600) begin
            @(posedge clk); #1;
            WaitReq_i = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
            cyc++;
        end
        WaitReq_i = 1'b0;
        check("ack", W'(ack_cnt - a0), W'(1));
        if (!valid) begin
            check("ack_lat", W'(cyc <= 3), W'(1));
            check("no_bus", W'((rd_cnt - r0) + (wr_cnt - w0)), '0);
        end else begin
            check("nwrites", W'(wr_cnt - w0), W'(h));
        end
        check("wr_left", W'(exp_wa.size()), '0);
        check("rd_left", W'(exp_rd.size()), '0);
        @(negedge clk);
        check("lock_idle", W'(Lock_o), '0);
        check("ack_once", W'(ack_cnt - a0), W'(1));
    endtask

    task automatic reset_mid_job();
        int a0, r0, w0, cyc;
        a0 = ack_cnt; r0 = rd_cnt; w0 = wr_cnt;
        start_job(3'd2, 9'd4, 4'd1, 1'b1, 1'b0);
        cyc = 0;
        while (rd_cnt < r0 + 2 && cyc < 100) begin @(negedge clk); cyc++; end
        check("rst_second_rd", W'(rd_cnt - r0), W'(2));
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        check("rst_read", W'(Read_o), '0);
        check("rst_write", W'(Write_o), '0);
        check("rst_lock", W'(Lock_o), '0);
        check("rst_ack", W'(Ack_o), '0);
        check("rst_addr", W'(Addr_o), '0);
        check("rst_wdata", WriteData_o, '0);
        repeat (5) @(negedge clk);
        check("rst_no_ack", W'(ack_cnt - a0), '0);
        check("rst_writes", W'(wr_cnt - w0), W'(1));
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_idle_bus", W'((rd_cnt - r0) + (wr_cnt - w0)), W'(3));
        run_job(3'd2, 9'd4, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] w;
        rstn = 1'b0; Req_i = 1'b0; select = '0; Height_i = '0; LeakyBp_i = '0; WaitReq_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ack", W'(Ack_o), '0);
        check("reset_read", W'(Read_o), '0);
        check("reset_write", W'(Write_o), '0);
        check("reset_lock", W'(Lock_o), '0);
        check("reset_addr", W'(Addr_o), '0);
        check("reset_wdata", WriteData_o, '0);
        rstn = 1'b1;

        w = {32'h8000_0000, 32'h0, 32'hFFFF_FFF9, 32'd5};
        mem[B0] = w; mem[B0 + 1] = w; mem[B0 + 2] = w;
        run_job(3'd0, 9'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        w = {32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd9};
        mem[B3] = w;
        run_job(3'd3, 9'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        run_job(3'd1, 9'd2, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        run_job(3'd0, 9'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(3'd6, 9'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(3'd4, 9'd4, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        reset_mid_job();

        for (int j = 0; j < 10; j++) begin
            run_job(3'($urandom_range(0, 4)), 9'($urandom_range(1, 6)), 4'($urandom),
                    1'($urandom), 1'b0, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/relu_act.md
RELU_ACT -- requirements
Module: relu_act

Interface
REQ-001 SHALL have parameter ShareMemAddr, default 64'h0, base word address for select 3'b000.
REQ-002 SHALL have parameter PrivateMemAddr0, default 64'h0, base word address for select 3'b001.
REQ-003 SHALL have parameters PrivateMemAddr1/2/3, default 64'h0, base word addresses for select 3'b010/3'b011/3'b100.
REQ-004 SHALL have parameter RAM_WIDTH, default 512, bus data width in bits, a multiple of 32.
REQ-005 SHALL have port clk input 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rstn input 1, asynchronous active-low reset.
REQ-007 SHALL have port select input 3, memory region select.
REQ-008 SHALL have port Height_i input 9, number of RAM_WIDTH words to process.
REQ-009 SHALL have port LeakyBp_i input 4, arithmetic right-shift applied to negative lanes (REQ-030 only).
REQ-010 SHALL have port Req_i input 1, start request from bus interface.
REQ-011 SHALL have port Ack_o output 1, one-cycle completion pulse.
REQ-012 SHALL have ports Addr_o output 64, Read_o output 1, Write_o output 1, word address and strobes.
REQ-013 SHALL have ports ByteEnable_o output 64 (constant all ones), WriteData_o output RAM_WIDTH, ReadData_i input RAM_WIDTH.
REQ-014 SHALL have ports Lock_o output 1 (bus held while busy), WaitReq_i input 1 (bus stall).

Function
REQ-015 SHALL implement states IDLE, RD_REQ, RD_WAIT, PROC, WR_REQ, DONE.
REQ-016 IDLE: on Req_i=1 latch Height_i and base address from select, assert Lock_o, go RD_REQ; Req_i outside IDLE ignored.
REQ-017 Height_i=0 or select in 3'b101..3'b111: no bus access, go DONE directly.
REQ-018 RD_REQ: when WaitReq_i=0, assert Read_o for exactly one cycle with Addr_o=current address, go RD_WAIT; while WaitReq_i=1 hold, Read_o=0.
REQ-019 RD_WAIT: ReadData_i SHALL be captured exactly 2 cycles after the Read_o cycle; then go PROC.
REQ-020 PROC: register per-lane result for each signed 32-bit lane k: out = (lane<0) ? 0 : lane; one cycle; go WR_REQ.
REQ-021 WR_REQ: when WaitReq_i=0, assert Write_o for exactly one cycle with Addr_o=same address as the read (in-place) and WriteData_o=result; while WaitReq_i=1 hold, Write_o=0, WriteData_o stable.
REQ-022 After each write: address+1, remaining count-1; remaining=0 -> DONE, else RD_REQ.
REQ-023 DONE: Ack_o=1 for one cycle, Lock_o=0, return IDLE.
REQ-024 Read_o and Write_o SHALL never be high in the same cycle.
REQ-025 Minimum per-word latency: 6 cycles (RD_REQ, 2x RD_WAIT, PROC, WR_REQ, plus address update) with WaitReq_i=0.
REQ-026 Lane value 32'h8000_0000 SHALL output 0; 32'h0000_0000 passes unchanged.
REQ-027 Address SHALL wrap modulo 2^64 without error.

Reset
REQ-028 rstn=0 SHALL immediately force state IDLE, Ack_o=0, Read_o=0, Write_o=0, Lock_o=0, Addr_o=0, WriteData_o=0, counters and latched address=0.
REQ-029 Reset mid-operation SHALL abandon the job with no further bus access and no Ack_o; a new Req_i is required.

Configuration
REQ-030 With macro RELU_LEAKY_EN defined, negative lanes SHALL output lane >>> LeakyBp_i (arithmetic, sign-preserving) instead of 0; LeakyBp_i=0 passes negatives unchanged.
REQ-031 Without RELU_LEAKY_EN, LeakyBp_i SHALL be ignored and negatives forced to 0.

Verification
REQ-032 select=000, ShareMemAddr=0x100, Height_i=3, words with lanes {5,-7,0,0x80000000} -> writes at 0x100..0x102 with lanes {5,0,0,0}, one Ack_o after the third write.
REQ-033 WaitReq_i=1 for 4 cycles during RD_REQ and WR_REQ -> Read_o/Write_o stay 0, issue once on release, data unchanged.
REQ-034 Height_i=0 -> no Read_o/Write_o, Ack_o pulse within 3 cycles of Req_i.
REQ-035 rstn low during RD_WAIT of word 2 of 4 -> all outputs 0 same cycle, no Ack_o, next Req_i restarts at base.
REQ-036 RELU_LEAKY_EN, LeakyBp_i=2, lane -16 -> -4; lane -1 -> -1; lane 9 -> 9.
REQ-037 select=3'b110, Height_i=5 -> no bus access, Ack_o pulse, Lock_o low after.
